// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a scanned 4-digit seven-segment bus
// (sel/seg) and rebuilds the displayed hex digits as atomic frames.
// In : sys_clk, sys_rst_p (sync, active-high), sel[3:0], seg[6:0] (a..g)
// Out: digits[15:0], valid_mask[3:0], frame_done, data_valid,
//      err_invalid, err_multi_sel, stale
module seg7_scan_decoder #(
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int SETTLE         = 4,
  parameter int TIMEOUT_MAX    = 262143
) (
  input  logic        sys_clk,
  input  logic        sys_rst_p,
  input  logic [3:0]  sel,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  valid_mask,
  output logic        frame_done,
  output logic        data_valid,
  output logic        err_invalid,
  output logic        err_multi_sel,
  output logic        stale
);

  localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [17:0] TMO_MAX   = 18'(TIMEOUT_MAX);
  localparam logic [17:0] TMO_M1    = 18'(TIMEOUT_MAX - 1);

  typedef enum logic {
    S_SCAN,
    S_COMMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        w_commit;

  logic [10:0] w_norm;
  logic [10:0] r_sync1;
  logic [10:0] r_sync2;
  logic [10:0] r_cmp;
  logic [7:0]  r_cnt;
  logic        r_captured;

  logic [3:0]  w_sel;
  logic [6:0]  w_seg;
  logic        w_same;
  logic        w_settle;
  logic        w_multi;
  logic        w_cap;
  logic [1:0]  w_idx;
  logic [3:0]  w_hex;
  logic        w_hex_ok;
  logic        w_tmo_hit;
  logic [3:0]  w_seen_base;

  logic [15:0] r_shadow;
  logic [3:0]  r_smask;
  logic [3:0]  r_seen;
  logic [17:0] r_tmo;

  assign w_norm = {sel ^ {4{SEL_ACTIVE_LOW}},
                   seg ^ {7{SEG_ACTIVE_LOW}}};

  assign w_sel    = r_sync2[10:7];
  assign w_seg    = r_sync2[6:0];
  assign w_same   = (r_sync2 == r_cmp);
  // fires once per dwell, on the cycle the sample has been stable long enough
  assign w_settle = w_same && (r_cnt == SETTLE_M1) && !r_captured;
  assign w_multi  = (w_sel & (w_sel - 4'd1)) != 4'd0;
  assign w_cap    = w_settle && (w_sel != 4'd0) && !w_multi;
  assign w_idx    = {w_sel[2] | w_sel[3], w_sel[1] | w_sel[3]};

  assign w_tmo_hit = !w_cap && (r_tmo == TMO_M1);
  // commit/timeout clear happens before a same-cycle capture lands
  assign w_seen_base = (w_commit || w_tmo_hit) ? 4'd0 : r_seen;

  always_comb begin
    w_hex_ok = 1'b1;
    w_hex    = 4'h0;
    case (w_seg)
      7'h3F: w_hex = 4'h0;
      7'h06: w_hex = 4'h1;
      7'h5B: w_hex = 4'h2;
      7'h4F: w_hex = 4'h3;
      7'h66: w_hex = 4'h4;
      7'h6D: w_hex = 4'h5;
      7'h7D: w_hex = 4'h6;
      7'h07: w_hex = 4'h7;
      7'h7F: w_hex = 4'h8;
      7'h6F: w_hex = 4'h9;
      7'h77: w_hex = 4'hA;
      7'h7C: w_hex = 4'hB;
      7'h39: w_hex = 4'hC;
      7'h5E: w_hex = 4'hD;
      7'h79: w_hex = 4'hE;
      7'h71: w_hex = 4'hF;
      default: w_hex_ok = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cmp      <= '0;
      r_cnt      <= '0;
      r_captured <= 1'b0;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
      r_cmp   <= r_sync2;
      if (!w_same) begin
        r_cnt      <= '0;
        r_captured <= 1'b0;
      end else begin
        if (r_cnt != SETTLE_M1) r_cnt <= r_cnt + 8'd1;
        if (w_settle) r_captured <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) r_state <= S_SCAN;
    else           r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_commit   = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (w_cap && ((r_seen | w_sel) == 4'hF))
          w_state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit   = 1'b1;
        w_state_nx = S_SCAN;
      end
      default: w_state_nx = S_SCAN;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      r_shadow <= '0;
      r_smask  <= '0;
      r_seen   <= '0;
      r_tmo    <= '0;
    end else begin
      r_seen <= w_seen_base | (w_cap ? w_sel : 4'd0);
      if (w_cap) begin
        r_shadow[{w_idx, 2'b00} +: 4] <= w_hex_ok ? w_hex : 4'h0;
        r_smask[w_idx]                <= w_hex_ok;
      end
      if (w_cap)               r_tmo <= '0;
      else if (r_tmo != TMO_MAX) r_tmo <= r_tmo + 18'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      digits        <= '0;
      valid_mask    <= '0;
      frame_done    <= 1'b0;
      data_valid    <= 1'b0;
      err_invalid   <= 1'b0;
      err_multi_sel <= 1'b0;
      stale         <= 1'b0;
    end else begin
      frame_done    <= w_commit;
      err_invalid   <= w_cap && !w_hex_ok && (w_seg != 7'd0);
      err_multi_sel <= w_settle && w_multi;
      if (w_commit) begin
        digits     <= r_shadow;
        valid_mask <= r_smask;
      end
      if (w_commit)       data_valid <= 1'b1;
      else if (w_tmo_hit) data_valid <= 1'b0;
      if (w_cap)          stale <= 1'b0;
      else if (w_tmo_hit) stale <= 1'b1;
    end
  end

endmodule
